// File: rtl/rr_mux4x32_arbiter_pkg.sv
// Shared types and constants for the round-robin result-path arbiter.
// Holds the rotate-priority pick used to choose the next winner.
package rr_mux4x32_arbiter_pkg;

    localparam int WIDTH = 32;
    localparam int REQ_N = 4;

    typedef logic [WIDTH-1:0] data_t;
    typedef logic [REQ_N-1:0] req_t;
    typedef logic [1:0]       idx_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // First requester after ptr, scanning ptr+1 .. ptr+4 modulo 4.
    function automatic idx_t rr_pick(req_t req, idx_t ptr);
        idx_t w;
        idx_t c;
        w = ptr;
        for (int k = REQ_N; k >= 1; k--) begin
            c = ptr + idx_t'(k);
            if (req[c]) w = c;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_mux4x32_arbiter_if.sv
// Requester/consumer bundle of the arbiter.
// slave is the arbiter side, master the producer/consumer side.
interface rr_mux4x32_arbiter_if;
    import rr_mux4x32_arbiter_pkg::*;

    req_t  req;
    data_t a0;
    data_t a1;
    data_t a2;
    data_t a3;
    req_t  gnt;
    idx_t  sel;
    data_t y;
    logic  out_valid;
    logic  out_ready;

    modport slave (
        input  req, a0, a1, a2, a3, out_ready,
        output gnt, sel, y, out_valid
    );

    modport master (
        output req, a0, a1, a2, a3, out_ready,
        input  gnt, sel, y, out_valid
    );

endinterface

// File: rtl/rr_mux4x32_arbiter_mux.sv
// Existing 4:1 32-bit datapath mux, select s_i.
// Purely combinational.
module mux4x32
    import rr_mux4x32_arbiter_pkg::*;
(
    input  data_t a0_i,
    input  data_t a1_i,
    input  data_t a2_i,
    input  data_t a3_i,
    input  idx_t  s_i,
    output data_t y_o
);

    always_comb begin
        y_o = a0_i;
        unique case (s_i)
            2'd0: y_o = a0_i;
            2'd1: y_o = a1_i;
            2'd2: y_o = a2_i;
            2'd3: y_o = a3_i;
        endcase
    end

endmodule

// File: rtl/rr_mux4x32_arbiter.sv
// Round-robin arbiter sharing one registered 32-bit result path
// between four producers behind a valid/ready handshake.
module rr_mux4x32_arbiter
    import rr_mux4x32_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    rr_mux4x32_arbiter_if.slave   bus
);

    state_e state_q;
    data_t  y_q;
    data_t  y_d;
    idx_t   sel_q;
    idx_t   ptr_q;
    idx_t   win;
    logic   cap;

    assign win = rr_pick(bus.req, ptr_q);

    // Capture when the output slot is empty or drains on this edge.
    assign cap = rst_n && (|bus.req) &&
                 ((state_q == EMPTY) || bus.out_ready);

    assign bus.gnt = cap ? (req_t'(1) << win) : '0;

    mux4x32 u_mux (
        .a0_i (bus.a0),
        .a1_i (bus.a1),
        .a2_i (bus.a2),
        .a3_i (bus.a3),
        .s_i  (win),
        .y_o  (y_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            y_q     <= '0;
            sel_q   <= '0;
            ptr_q   <= 2'd3;
        end else if (cap) begin
            state_q <= FULL;
            y_q     <= y_d;
            sel_q   <= win;
            ptr_q   <= win;
        end else if ((state_q == FULL) && bus.out_ready) begin
            state_q <= EMPTY;
        end
    end

    assign bus.y         = y_q;
    assign bus.sel       = sel_q;
    assign bus.out_valid = (state_q == FULL);

endmodule

// File: tb/tb_rr_mux4x32_arbiter.sv
// Bench for rr_mux4x32_arbiter: directed scenarios plus random
// traffic checked every cycle against a behavioural model.
module tb_rr_mux4x32_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rr_mux4x32_arbiter_if bus ();

    rr_mux4x32_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] av [4];
    bit          m_valid;
    logic [31:0] m_y;
    int          m_sel;
    int          m_ptr;
    logic [3:0]  obs_gnt;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_y     = '0;
        m_sel   = 0;
        m_ptr   = 3;
    endtask

    // Drive one cycle, check against the model, advance across the edge.
    task automatic step(input logic [3:0] r, input logic rdy);
        int          w;
        bit          c;
        logic [3:0]  eg;
        bus.req       = r;
        bus.a0        = av[0];
        bus.a1        = av[1];
        bus.a2        = av[2];
        bus.a3        = av[3];
        bus.out_ready = rdy;
        #1;
        w = -1;
        for (int k = 1; k <= 4; k++) begin
            if (w < 0 && r[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
        end
        c  = (w >= 0) && (!m_valid || rdy);
        eg = c ? 4'(1 << w) : 4'b0;
        obs_gnt = bus.gnt;
        chk("gnt", 32'(bus.gnt), 32'(eg));
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("y", bus.y, m_y);
        chk("sel", 32'(bus.sel), 32'(m_sel));
        @(posedge clk);
        if (c) begin
            m_y     = av[w];
            m_sel   = w;
            m_ptr   = w;
            m_valid = 1;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_y", bus.y, 32'h0);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.req = '0;
        bus.a0 = '0; bus.a1 = '0; bus.a2 = '0; bus.a3 = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) av[i] = 32'(i);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Reset while FULL holding DEADBEEF: cleared before any edge.
        av[0] = 32'hDEADBEEF;
        step(4'b0001, 1'b0);
        chk("full_y", bus.y, 32'hDEADBEEF);
        bus.req = 4'b1111;
        do_reset();

        // Single request.
        av[0] = 32'h0;
        step(4'b0100, 1'b1);
        chk("single_gnt", 32'(obs_gnt), 32'h4);
        chk("single_y", bus.y, 32'h2);
        chk("single_sel", 32'(bus.sel), 32'h2);
        chk("single_valid", 32'(bus.out_valid), 32'h1);
        do_reset();

        // Round-robin from reset.
        for (int i = 0; i < 5; i++) begin
            logic [3:0] eg;
            eg = 4'(1 << (i % 4));
            step(4'b1111, 1'b1);
            chk("rr_gnt", 32'(obs_gnt), 32'(eg));
            chk("rr_y", bus.y, 32'(i % 4));
            chk("rr_valid", 32'(bus.out_valid), 32'h1);
        end
        do_reset();

        // Backpressure with y=1 held.
        step(4'b1111, 1'b1);
        step(4'b1111, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 1'b0);
            chk("bp_gnt", 32'(obs_gnt), 32'h0);
            chk("bp_y", bus.y, 32'h1);
            chk("bp_sel", 32'(bus.sel), 32'h1);
        end
        step(4'b1111, 1'b1);
        chk("bp_rel_gnt", 32'(obs_gnt), 32'h4);
        chk("bp_rel_y", bus.y, 32'h2);

        // Pointer wrap from last winner 2.
        step(4'b0101, 1'b1);
        chk("wrap_gnt0", 32'(obs_gnt), 32'h1);
        step(4'b0101, 1'b1);
        chk("wrap_gnt2", 32'(obs_gnt), 32'h4);

        // Drain.
        step(4'b0000, 1'b1);
        chk("drain_valid", 32'(bus.out_valid), 32'h0);
        chk("drain_y", bus.y, 32'h2);
        chk("drain_sel", 32'(bus.sel), 32'h2);

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) av[i] = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                bus.req = 4'($urandom);
                do_reset();
            end else begin
                step(4'($urandom), 1'($urandom_range(0, 3) != 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
